// File: rtl/ifmap_glb_banked.sv
// Banked ifmap buffer: NUM_BANKS word banks, a full-row port A and a 1-word port B with a strided burst reader.
// Reads return data 1 cycle after the request. The burst stream stalls on bst_ready through a 2-entry skid FIFO, and issue pauses when the FIFO is full.
module ifmap_glb_banked #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_BANKS  = 4,
  parameter int DEPTH      = 154588,
  parameter int LEN_W      = 12,
  localparam int ROWS      = DEPTH / NUM_BANKS,
  localparam int RAW       = $clog2(ROWS),
  localparam int AW        = $clog2(DEPTH),
  localparam int BW        = $clog2(NUM_BANKS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            we_a,
  input  logic                            re_a,
  input  logic [RAW-1:0]                  addr_a,
  input  logic [DATA_WIDTH*NUM_BANKS-1:0] wdata_a,
  output logic [DATA_WIDTH*NUM_BANKS-1:0] rdata_a,
  output logic                            rvalid_a,
  input  logic                            we_b,
  input  logic                            re_b,
  input  logic [AW-1:0]                   addr_b,
  input  logic [DATA_WIDTH-1:0]           wdata_b,
  output logic [DATA_WIDTH-1:0]           rdata_b,
  output logic                            rvalid_b,
  input  logic                            bst_start,
  input  logic [AW-1:0]                   bst_base,
  input  logic [LEN_W-1:0]                bst_len,
  input  logic [LEN_W-1:0]                bst_stride,
  output logic [DATA_WIDTH-1:0]           bst_data,
  output logic                            bst_valid,
  input  logic                            bst_ready,
  output logic                            bst_busy,
  output logic                            bst_done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                         state_q, state_d;
  logic [AW-1:0]                  addr_q, addr_d;
  logic [LEN_W-1:0]               stride_q, stride_d;
  logic [LEN_W-1:0]               iss_left_q, iss_left_d;
  logic [LEN_W-1:0]               pop_left_q, pop_left_d;
  logic                           done_q, done_d;
  logic [DATA_WIDTH-1:0]          fifo_q [2];
  logic                           fifo_wp_q, fifo_rp_q;
  logic [1:0]                     fifo_cnt_q;
  logic [DATA_WIDTH*NUM_BANKS-1:0] rdata_a_q;
  logic                           rvalid_a_q, rvalid_b_q;
  logic [DATA_WIDTH-1:0]          b_lat_q [NUM_BANKS];
  logic [BW-1:0]                  b_sel_q;

  logic                           busy, issue, pop, b_rd;
  logic [AW-1:0]                  b_addr;
  logic [BW-1:0]                  b_bank;
  logic [RAW-1:0]                 b_row;
  logic [DATA_WIDTH-1:0]          a_word [NUM_BANKS];
  logic [DATA_WIDTH-1:0]          b_word [NUM_BANKS];

  assign busy   = (state_q != IDLE);
  // The burst engine owns port B whenever it is active.
  assign b_addr = busy ? addr_q : addr_b;
  assign b_bank = b_addr[BW-1:0];
  assign b_row  = RAW'(b_addr >> BW);
  assign b_rd   = re_b && !busy;
  assign pop    = bst_valid && bst_ready;

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [ROWS];
    logic                  b_we;
    assign b_we = we_b && !busy && (b_bank == BW'(k));
    // Port A write is applied last so it wins a same-row write collision.
    always_ff @(posedge clk) begin
      if (b_we) mem[b_row] <= wdata_b;
      if (we_a) mem[addr_a] <= wdata_a[k*DATA_WIDTH +: DATA_WIDTH];
    end
    assign a_word[k] = mem[addr_a];
    assign b_word[k] = mem[b_row];
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    stride_d   = stride_q;
    iss_left_d = iss_left_q;
    pop_left_d = pop_left_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    if (pop) pop_left_d = pop_left_q - LEN_W'(1);
    unique case (state_q)
      IDLE: begin
        if (bst_start && bst_len != '0) begin
          state_d    = RUN;
          addr_d     = bst_base;
          stride_d   = bst_stride;
          iss_left_d = bst_len;
          pop_left_d = bst_len;
        end
      end
      RUN: begin
        // Reads land in the FIFO on the issuing edge, so nothing is in flight when deciding.
        issue = (fifo_cnt_q != 2'd2);
        if (issue) begin
          addr_d     = addr_q + AW'(stride_q);
          iss_left_d = iss_left_q - LEN_W'(1);
          if (iss_left_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && pop_left_q == LEN_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      iss_left_q <= '0;
      pop_left_q <= '0;
      done_q     <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      fifo_wp_q  <= 1'b0;
      fifo_rp_q  <= 1'b0;
      fifo_cnt_q <= '0;
      rdata_a_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      b_sel_q    <= '0;
      for (int k = 0; k < NUM_BANKS; k++) b_lat_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      iss_left_q <= iss_left_d;
      pop_left_q <= pop_left_d;
      done_q     <= done_d;
      if (issue) begin
        fifo_q[fifo_wp_q] <= b_word[b_bank];
        fifo_wp_q         <= ~fifo_wp_q;
      end
      if (pop) fifo_rp_q <= ~fifo_rp_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, issue} - {1'b0, pop};
      rvalid_a_q <= re_a;
      if (re_a) begin
        for (int k = 0; k < NUM_BANKS; k++) rdata_a_q[k*DATA_WIDTH +: DATA_WIDTH] <= a_word[k];
      end
      rvalid_b_q <= b_rd;
      if (b_rd) b_sel_q <= b_bank;
      for (int k = 0; k < NUM_BANKS; k++) begin
        if (b_rd && b_bank == BW'(k)) b_lat_q[k] <= b_word[k];
      end
    end
  end

  assign rdata_a   = rdata_a_q;
  assign rvalid_a  = rvalid_a_q;
  assign rdata_b   = b_lat_q[b_sel_q];
  assign rvalid_b  = rvalid_b_q;
  assign bst_data  = fifo_q[fifo_rp_q];
  assign bst_valid = (fifo_cnt_q != 2'd0);
  assign bst_busy  = busy;
  assign bst_done  = done_q;

endmodule

// File: tb/tb_ifmap_glb_banked.sv
// Directed bench for ifmap_glb_banked: port A/B access, collisions, bursts with backpressure, mid-burst reset.
module tb_ifmap_glb_banked;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we_a = 1'b0, re_a = 1'b0;
  logic [15:0] addr_a = '0;
  logic [63:0] wdata_a = '0;
  logic [63:0] rdata_a;
  logic        rvalid_a;
  logic        we_b = 1'b0, re_b = 1'b0;
  logic [17:0] addr_b = '0;
  logic [15:0] wdata_b = '0;
  logic [15:0] rdata_b;
  logic        rvalid_b;
  logic        bst_start = 1'b0;
  logic [17:0] bst_base = '0;
  logic [11:0] bst_len = '0, bst_stride = '0;
  logic [15:0] bst_data;
  logic        bst_valid, bst_ready = 1'b0, bst_busy, bst_done;

  int n_chk = 0;
  int n_pass = 0;

  ifmap_glb_banked dut (
    .clk(clk), .rst(rst),
    .we_a(we_a), .re_a(re_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .rdata_a(rdata_a), .rvalid_a(rvalid_a),
    .we_b(we_b), .re_b(re_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .rdata_b(rdata_b), .rvalid_b(rvalid_b),
    .bst_start(bst_start), .bst_base(bst_base), .bst_len(bst_len),
    .bst_stride(bst_stride), .bst_data(bst_data), .bst_valid(bst_valid),
    .bst_ready(bst_ready), .bst_busy(bst_busy), .bst_done(bst_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [15:0] row, input logic [63:0] d);
    we_a = 1'b1; addr_a = row; wdata_a = d;
    tick();
    we_a = 1'b0;
  endtask

  // Rows 0..3 hold 16'h1000 + word address.
  function automatic logic [15:0] model(input logic [17:0] a);
    return 16'h1000 + a[15:0];
  endfunction

  task automatic run_burst(input logic [17:0] base, input logic [11:0] len,
                           input logic [11:0] stride, input bit toggle, input string tag);
    int got, dones, first, last_v, done_cyc;
    logic [15:0] prev_d;
    logic        prev_stall;
    logic [17:0] a;
    bst_start = 1'b1; bst_base = base; bst_len = len; bst_stride = stride; bst_ready = 1'b1;
    tick();
    bst_start = 1'b0;
    got = 0; dones = 0; first = -1; last_v = -1; done_cyc = -1;
    prev_stall = 1'b0; prev_d = '0; a = base;
    for (int cyc = 1; cyc < 30; cyc++) begin
      bst_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      if (prev_stall) begin
        check({tag, "_hold_vld"}, bst_valid, 1'b1);
        check({tag, "_hold_dat"}, bst_data, prev_d);
      end
      if (bst_valid) begin
        if (first < 0) first = cyc;
        last_v = cyc;
        if (got < int'(len)) check({tag, "_dat"}, bst_data, model(a));
        if (bst_ready) begin
          got++;
          a = a + 18'(stride);
        end
      end
      if (bst_done) begin
        dones++;
        done_cyc = cyc;
      end
      prev_stall = bst_valid && !bst_ready;
      prev_d = bst_data;
      tick();
    end
    check({tag, "_words"}, got, len);
    check({tag, "_first"}, first, 2);
    check({tag, "_dones"}, dones, 1);
    check({tag, "_busy_end"}, bst_busy, 1'b0);
    if (!toggle) begin
      check({tag, "_last"}, last_v, int'(len) + 1);
      check({tag, "_done_cyc"}, done_cyc, int'(len) + 2);
    end
  endtask

  initial begin
    logic [63:0] d;
    int busy_seen, done_seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rvalid_a", rvalid_a, 1'b0);
    check("rst_rvalid_b", rvalid_b, 1'b0);
    check("rst_rdata_a", rdata_a, 64'h0);
    check("rst_rdata_b", rdata_b, 16'h0);
    check("rst_bst", {bst_valid, bst_busy, bst_done}, 3'b000);
    check("rst_bst_data", bst_data, 16'h0);
    tick();
    rst = 1'b0;
    tick();

    // Port A row write, port B word reads.
    wr_a(16'd5, {16'd4, 16'd3, 16'd2, 16'd1});
    for (int i = 0; i < 4; i++) begin
      re_b = 1'b1; addr_b = 18'(20 + i);
      tick();
      re_b = 1'b0;
      @(negedge clk);
      check("rb_vld", rvalid_b, 1'b1);
      check("rb_dat", rdata_b, 16'(i + 1));
      tick();
    end
    @(negedge clk);
    check("rb_vld_idle", rvalid_b, 1'b0);
    tick();

    // Port B word write, port A row read.
    wr_a(16'd1, 64'h4444_3333_2222_1111);
    we_b = 1'b1; addr_b = 18'd7; wdata_b = 16'hBEEF;
    tick();
    we_b = 1'b0;
    re_a = 1'b1; addr_a = 16'd1;
    tick();
    re_a = 1'b0;
    @(negedge clk);
    check("ra_vld", rvalid_a, 1'b1);
    check("ra_dat", rdata_a, 64'hBEEF_3333_2222_1111);
    tick();
    @(negedge clk);
    check("ra_vld_idle", rvalid_a, 1'b0);
    check("ra_hold", rdata_a, 64'hBEEF_3333_2222_1111);
    tick();

    // Write/write collision: port A wins. Then read/write collision: old data.
    we_a = 1'b1; addr_a = 16'd2; wdata_a = 64'h00A3_00A2_00A1_00A0;
    we_b = 1'b1; addr_b = 18'd9; wdata_b = 16'h5555;
    tick();
    we_b = 1'b0;
    wdata_a = 64'h00B3_00B2_00B1_00B0;
    re_b = 1'b1;
    tick();
    we_a = 1'b0;
    @(negedge clk);
    check("ww_then_rw_old", rdata_b, 16'h00A1);
    tick();
    re_b = 1'b0;
    @(negedge clk);
    check("rw_new", rdata_b, 16'h00B1);
    tick();

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) d[k*16 +: 16] = 16'h1000 + 16'(4 * r + k);
      wr_a(16'(r), d);
    end

    run_burst(18'd0, 12'd8, 12'd1, 1'b0, "b8");
    run_burst(18'd0, 12'd4, 12'd4, 1'b1, "bs4");

    // Zero-length burst is a no-op.
    bst_start = 1'b1; bst_len = 12'd0;
    tick();
    bst_start = 1'b0;
    busy_seen = 0; done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      busy_seen += int'(bst_busy);
      done_seen += int'(bst_done);
      tick();
    end
    check("nop_busy", busy_seen, 0);
    check("nop_done", done_seen, 0);

    // Reset mid-burst with words pending; port B reads ignored while busy.
    bst_ready = 1'b0; bst_start = 1'b1; bst_base = 18'd0; bst_len = 12'd8; bst_stride = 12'd1;
    tick();
    bst_start = 1'b0; re_b = 1'b1; addr_b = 18'd20;
    for (int i = 0; i < 3; i++) tick();
    @(negedge clk);
    check("busy_rvb", rvalid_b, 1'b0);
    check("stall_vld", {bst_valid, bst_busy}, 2'b11);
    tick();
    rst = 1'b1;
    #2;
    check("arst_now", {bst_valid, bst_busy, bst_done}, 3'b000);
    @(negedge clk);
    check("arst_cyc", {bst_valid, bst_busy, bst_done}, 3'b000);
    tick();
    rst = 1'b0; re_b = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      done_seen += int'(bst_done);
      tick();
    end
    check("arst_no_done", done_seen, 0);
    run_burst(18'd4, 12'd4, 12'd1, 1'b0, "post");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
